// File: rtl/zipo_fetch_unit_pkg.sv
// zipo_fetch_unit_pkg: shared widths, PC step, reset PC and instruction-extraction helper for the fetch stage
`ifndef INITIAL_PC
`define INITIAL_PC 64'h0000_0000_0000_1000
`endif
package zipo_fetch_unit_pkg;
  localparam int RV_INSTR_W = 32;
  localparam int XLEN = 64;
  localparam int QENTRY_W = RV_INSTR_W + XLEN;
  localparam logic [XLEN-1:0] PC_INC = 64'd4;
  localparam logic [XLEN-1:0] DEFAULT_INITIAL_PC = `INITIAL_PC;
  function automatic logic [RV_INSTR_W-1:0] pick_instr(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] word);
    return pc[2] ? word[63:32] : word[31:0];
  endfunction
endpackage

// File: rtl/zipo_sync_fifo.sv
// zipo_sync_fifo: synchronous FIFO with flush; head data reads as zero while empty
module zipo_sync_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = empty ? '0 : mem[rd_ptr];
  // pointers and occupancy; flush behaves like reset
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
  // storage needs no reset: entries are only read while counted as valid
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/zipo_fetch_unit.sv
// zipo_fetch_unit: in-order instruction fetch with slot-reserved queue and redirect flush
module zipo_fetch_unit
  import zipo_fetch_unit_pkg::*;
#(
  parameter logic [63:0] INITIAL_PC = DEFAULT_INITIAL_PC,
  parameter int QUEUE_DEPTH = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [63:0] mem_addr,
  input  logic        mem_resp_valid,
  input  logic [63:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [63:0] out_pc,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc
);
  localparam int QCW = $clog2(QUEUE_DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  logic [XLEN-1:0] fetch_pc, flight_pc;
  logic [OW-1:0] outstanding, drop_count, f_count;
  logic [QCW-1:0] q_count;
  logic [QENTRY_W-1:0] q_head;
  logic accept, resp_keep, q_empty, q_full, f_empty, f_full;
  logic unused_bits;
  assign unused_bits = ^{f_count, f_empty, f_full, q_full, redirect_pc[1:0]};
  assign mem_req_valid = !rst && !redirect_valid && int'(outstanding) < MAX_OUTSTANDING
                         && int'(q_count) + int'(outstanding) < QUEUE_DEPTH;
  assign mem_addr = {fetch_pc[XLEN-1:3], 3'b000};
  assign accept = mem_req_valid && mem_req_ready;
  assign resp_keep = mem_resp_valid && drop_count == '0;
  assign out_valid = !q_empty;
  assign {out_instr, out_pc} = q_head;
  // fetch PC, request accounting and stale-response drop counter
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= {INITIAL_PC[XLEN-1:2], 2'b00};
      outstanding <= '0;
      drop_count <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      outstanding <= outstanding - OW'(mem_resp_valid);
      drop_count <= outstanding - OW'(mem_resp_valid);
    end else begin
      if (accept) fetch_pc <= fetch_pc + PC_INC;
      outstanding <= outstanding + OW'(accept) - OW'(mem_resp_valid);
      if (mem_resp_valid && drop_count != '0) drop_count <= drop_count - OW'(1);
    end
  end
  zipo_sync_fifo #(.W(XLEN), .DEPTH(MAX_OUTSTANDING)) u_flight (
    .clk(clk), .rst(rst), .flush(redirect_valid),
    .push(accept), .din(fetch_pc), .pop(resp_keep), .dout(flight_pc),
    .count(f_count), .empty(f_empty), .full(f_full)
  );
  zipo_sync_fifo #(.W(QENTRY_W), .DEPTH(QUEUE_DEPTH)) u_queue (
    .clk(clk), .rst(rst), .flush(redirect_valid),
    .push(resp_keep && !redirect_valid), .din({pick_instr(flight_pc, mem_rdata), flight_pc}),
    .pop(out_ready), .dout(q_head),
    .count(q_count), .empty(q_empty), .full(q_full)
  );
endmodule

// File: tb/tb_zipo_fetch_unit.sv
// tb_zipo_fetch_unit: directed scenarios against a latency-configurable in-order memory and a PC-order scoreboard
module tb_zipo_fetch_unit;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst, mem_req_valid, mem_req_ready, mem_resp_valid, out_valid, out_ready, redirect_valid;
  logic [63:0] mem_addr, mem_rdata, out_pc, redirect_pc;
  logic [31:0] out_instr;
  zipo_fetch_unit #(.INITIAL_PC(64'h1000), .QUEUE_DEPTH(4), .MAX_OUTSTANDING(2)) dut (
    .clk(clk), .rst(rst), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );
  typedef struct { logic [63:0] a; int due; } pend_t;
  pend_t pend[$];
  logic [63:0] addrs[$];
  logic [63:0] got[$];
  int checks = 0, failures = 0, cyc = 0, lat = 1, npop = 0, max_pend = 0;
  logic [63:0] exp_pc;
  logic saw_resp, saw_valid;

  function automatic logic [63:0] word_at(input logic [63:0] a);
    return {16'hBEEF, a[15:0] | 16'h0004, 16'hC0DE, a[15:0]};
  endfunction
  function automatic logic [31:0] exp_instr(input logic [63:0] p);
    return {p[2] ? 16'hBEEF : 16'hC0DE, p[15:0]};
  endfunction

  task automatic step();
    mem_resp_valid = 0;
    mem_rdata = '0;
    if (rst) pend.delete();
    else if (pend.size() > 0 && pend[0].due <= cyc) begin
      mem_resp_valid = 1;
      mem_rdata = word_at(pend[0].a);
      void'(pend.pop_front());
    end
    #1;
    saw_resp = mem_resp_valid;
    saw_valid = out_valid;
    if (mem_req_valid && mem_req_ready) begin
      pend.push_back('{a: mem_addr, due: cyc + lat});
      addrs.push_back(mem_addr);
    end
    if (pend.size() > max_pend) max_pend = pend.size();
    if (out_valid && out_ready && !redirect_valid && !rst) begin
      checks++;
      if (out_pc !== exp_pc) begin failures++; $display("FAIL out_pc got=%h exp=%h", out_pc, exp_pc); end
      checks++;
      if (out_instr !== exp_instr(exp_pc)) begin failures++; $display("FAIL out_instr pc=%h got=%h exp=%h", exp_pc, out_instr, exp_instr(exp_pc)); end
      got.push_back(out_pc);
      exp_pc += 64'd4;
      npop++;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1; mem_req_ready = 1; out_ready = 1; redirect_valid = 0; redirect_pc = '0; lat = 1;
    step(); step();
    #1;
    checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", mem_req_valid); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (out_instr !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=0", out_instr); end
    checks++; if (out_pc !== 64'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", out_pc); end
    rst = 0;
    #1;
    checks++; if (mem_req_valid !== 1'b1 || mem_addr !== 64'h1000) begin failures++; $display("FAIL first_req got=%b/%h exp=1/1000", mem_req_valid, mem_addr); end
    exp_pc = 64'h1000; addrs.delete(); got.delete(); npop = 0;
  endtask

  task automatic test_stream();
    repeat (22) step();
    checks++; if (npop != 20) begin failures++; $display("FAIL throughput got=%0d exp=20", npop); end
    checks++;
    if (addrs.size() < 3 || addrs[0] !== 64'h1000 || addrs[1] !== 64'h1000 || addrs[2] !== 64'h1008) begin
      failures++; $display("FAIL stream_addrs got=%h,%h,%h exp=1000,1000,1008", addrs[0], addrs[1], addrs[2]);
    end
  endtask

  task automatic test_backpressure();
    int n0;
    out_ready = 0;
    repeat (20) step();
    #1;
    checks++; if (out_valid !== 1'b1 || out_pc !== exp_pc) begin failures++; $display("FAIL stall_head got=%b/%h exp=1/%h", out_valid, out_pc, exp_pc); end
    checks++; if (mem_req_valid !== 1'b0 || pend.size() != 0) begin failures++; $display("FAIL stall_req got=%b/%0d exp=0/0", mem_req_valid, pend.size()); end
    mem_req_ready = 0; out_ready = 1; n0 = npop;
    repeat (10) step();
    #1;
    checks++; if (npop - n0 != 4) begin failures++; $display("FAIL buffered got=%0d exp=4", npop - n0); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL drained got=%b exp=0", out_valid); end
    mem_req_ready = 1; n0 = npop;
    repeat (10) step();
    checks++; if (npop - n0 < 7) begin failures++; $display("FAIL resume got=%0d exp>=7", npop - n0); end
  endtask

  task automatic test_latency();
    int n0;
    lat = 3; max_pend = 0; n0 = npop;
    repeat (30) step();
    checks++; if (max_pend != 2) begin failures++; $display("FAIL max_outstanding got=%0d exp=2", max_pend); end
    checks++; if (npop - n0 < 10) begin failures++; $display("FAIL latency_progress got=%0d exp>=10", npop - n0); end
  endtask

  task automatic test_redirect();
    for (int i = 0; i < 10 && pend.size() != 2; i++) step();
    checks++; if (pend.size() != 2) begin failures++; $display("FAIL pre_redirect_outstanding got=%0d exp=2", pend.size()); end
    redirect_valid = 1; redirect_pc = 64'h2002;
    #1;
    checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL redirect_req got=%b exp=0", mem_req_valid); end
    step();
    redirect_valid = 0; exp_pc = 64'h2000; addrs.delete(); got.delete();
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL redirect_flush got=%b exp=0", out_valid); end
    repeat (20) step();
    checks++; if (addrs.size() == 0 || addrs[0] !== 64'h2000) begin failures++; $display("FAIL redirect_addr got=%h exp=2000", addrs[0]); end
    checks++; if (got.size() == 0 || got[0] !== 64'h2000) begin failures++; $display("FAIL redirect_first_pc got=%h exp=2000", got[0]); end
  endtask

  task automatic test_redirect_same_cycle();
    lat = 1;
    repeat (6) step();
    redirect_valid = 1; redirect_pc = 64'h3000;
    step();
    checks++; if (!(saw_resp && saw_valid)) begin failures++; $display("FAIL busy_redirect resp=%b valid=%b exp=1/1", saw_resp, saw_valid); end
    redirect_valid = 0; exp_pc = 64'h3000; addrs.delete(); got.delete();
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL same_cycle_flush got=%b exp=0", out_valid); end
    checks++; if (mem_req_valid !== 1'b1 || mem_addr !== 64'h3000) begin failures++; $display("FAIL same_cycle_req got=%b/%h exp=1/3000", mem_req_valid, mem_addr); end
    repeat (10) step();
    checks++; if (got.size() < 5 || got[0] !== 64'h3000) begin failures++; $display("FAIL same_cycle_first got=%h n=%0d exp=3000", got[0], got.size()); end
  endtask

  task automatic test_back_to_back();
    redirect_valid = 1; redirect_pc = 64'h4000;
    step();
    redirect_pc = 64'h5004;
    step();
    redirect_valid = 0; exp_pc = 64'h5004; addrs.delete(); got.delete();
    repeat (10) step();
    checks++; if (addrs.size() == 0 || addrs[0] !== 64'h5000) begin failures++; $display("FAIL b2b_addr got=%h exp=5000", addrs[0]); end
    checks++; if (got.size() == 0 || got[0] !== 64'h5004) begin failures++; $display("FAIL b2b_first_pc got=%h exp=5004", got[0]); end
  endtask

  task automatic test_reset_mid();
    out_ready = 0;
    repeat (20) step();
    #1;
    checks++; if (out_valid !== 1'b1 || mem_req_valid !== 1'b0) begin failures++; $display("FAIL full_before_rst got=%b/%b exp=1/0", out_valid, mem_req_valid); end
    rst = 1;
    step();
    #1;
    checks++; if (out_valid !== 1'b0 || mem_req_valid !== 1'b0) begin failures++; $display("FAIL mid_reset got=%b/%b exp=0/0", out_valid, mem_req_valid); end
    rst = 0; out_ready = 1; exp_pc = 64'h1000; addrs.delete(); got.delete();
    #1;
    checks++; if (mem_req_valid !== 1'b1 || mem_addr !== 64'h1000) begin failures++; $display("FAIL restart_req got=%b/%h exp=1/1000", mem_req_valid, mem_addr); end
    repeat (10) step();
    checks++; if (got.size() < 5 || got[0] !== 64'h1000) begin failures++; $display("FAIL restart_first got=%h n=%0d exp=1000", got[0], got.size()); end
  endtask

  initial begin
    rst = 1; mem_req_ready = 1; mem_resp_valid = 0; mem_rdata = '0;
    out_ready = 1; redirect_valid = 0; redirect_pc = '0; exp_pc = 64'h1000;
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_latency();
    test_redirect();
    test_redirect_same_cycle();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
